vector_dot_acc: RTL and testbench
=================================

# vector_dot_acc

Parametrised signed fixed-point dot-product accelerator behind a 2-bit-address memory-mapped slave port, the next generation of the single-channel `vector_dot` block. It accepts operand pairs by register write and multiply-accumulates them through a 2-stage pipeline at one pair per cycle. It counts elements against a programmable vector length, raises done and an optional interrupt, and flags overflow with selectable saturate or wrap. It sits on the same CPU-side bus as `vector_dot`.

## Interface

- DATA_W, 16, operand width in bits (signed two's complement); valid range 2..32
- ACC_W, 40, accumulator width; valid range 32..64, must be ≥ 2*DATA_W
- LEN_W, 16, element counter and length register width; valid range 1..32
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- address  in  2  register select
- writedata  in  32  write data
- write  in  1  write strobe, one transfer per cycle
- read  in  1  read strobe
- readdata  out  32  registered read data, fixed read latency 1
- irq  out  1  registered, equals done & irq_en

## Operation

Writes:
- addr 0: opA <= writedata[DATA_W-1:0].
- addr 1: opB taken from writedata[DATA_W-1:0]; issues opA*opB into the pipeline. It is ignored while done=1.
- addr 2: LENGTH <= writedata[LEN_W-1:0]. Also clears acc, count, done, ovf, and flushes the pipeline.
- addr 3: bit0 = clear (acc, count, done, ovf, pipeline flush; not self-held), bit1 = irq_en (stored).

Reads, returned on readdata the next cycle:
- addr 0: acc[31:0].
- addr 1: acc[ACC_W-1:32], sign-extended to 32 bits.
- addr 2: count, zero-extended.
- addr 3: {28'b0, irq_en, ovf, busy, done}.

Pipeline:
- S1 registers the full 2*DATA_W signed product and a valid bit.
- S2 sign-extends the product to ACC_W+1 bits and adds it to acc.
- Overflow is detected when the top two bits of the sum differ. On overflow, ovf is set (sticky).
- With SATURATE=1, acc clamps to the max or min signed ACC_W value. With SATURATE=0, acc keeps the low ACC_W bits.
- count increments in the same cycle acc updates.
- done is set in the cycle count becomes LENGTH. LENGTH=0 means unbounded: done is never set.
- busy = S1 valid | S2 valid.

Reset values: readdata=0, irq=0, acc=0, count=0, done=0, ovf=0, irq_en=0, opA=0, LENGTH=0, pipeline valid bits=0.

## Timing

- Write of addr 1 sampled at edge T: product is registered at T+1, and acc, count and done update at T+2. irq asserts at T+3.
- Throughput is one pair per cycle. Back-to-back addr 1 writes need no stalls. opA may be rewritten every other cycle.
- Write of opA and addr 1 in consecutive cycles: the addr 1 multiply uses the opA value registered at the earlier edge.
- A read sampled at edge T drives readdata from edge T+1. readdata holds its value when read=0.
- A read concurrent with a pipeline update returns the pre-update value.
- Clear or LENGTH write in the same cycle as S2 completing: clear wins, and the in-flight result is discarded.
- An addr 1 write in the same cycle as clear is discarded.
- Element count reaching LENGTH while further pairs are in flight: those pairs are still accumulated, and count continues past LENGTH. Only new addr 1 writes after done is set are dropped.
- Reset mid-operation: all state returns to reset values at that edge, and in-flight products are lost.

## Test plan

- Reset, LENGTH=3, irq_en=1, pairs (1,2),(3,4),(5,6) -> addr 0 reads 44, addr 1 reads 0, count=3, done=1, irq=1 three cycles after the last addr 1 write.
- LENGTH=2, pairs (-3,7),(2,-5) -> addr 0 reads 0xFFFFFFE1, addr 1 reads 0xFFFFFFFF, ovf=0.
- ACC_W=32 and SATURATE=1, three pairs (32767,32767) -> acc 0x7FFFFFFF, ovf=1. Same with SATURATE=0 -> 0xBFFD0003, ovf=1.
- Five consecutive-cycle addr 1 writes with opA=2 and opB=1..5 -> acc=30 and count=5 exactly two cycles after the last write. busy deasserts the same cycle.
- LENGTH=1, pair (4,4), then an extra (9,9) after done -> acc stays 16. A clear written in the same cycle as a pending S2 gives acc=0 and count=0.
- Reset asserted for one cycle during streaming -> all reads return 0 the following cycles, and irq=0.

Source files
------------

// File: rtl/vector_dot_acc.sv
// rtl/vector_dot_acc.sv - register-mapped signed fixed-point dot-product accelerator
module vector_dot_acc #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int LEN_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic [LEN_W-1:0]         length;
    logic [LEN_W-1:0]         count;
    logic [LEN_W-1:0]         count_next;
    logic                     irq_en;
    logic                     done;
    logic                     ovf;
    logic                     busy;

    // stage 1: registered full-width product
    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    // stage 2: accumulate with one guard bit for overflow detection
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    prod_ext;
    logic signed [ACC_W:0]    sum;
    logic                     sum_ovf;
    logic signed [ACC_W-1:0]  acc_next;

    logic                     wr_a;
    logic                     wr_len;
    logic                     wr_ctl;
    logic                     issue;
    logic                     flush;
    logic [31:0]              rd_mux;

    assign op_b   = writedata[DATA_W-1:0];
    assign wr_a   = write && (address == 2'd0);
    assign wr_len = write && (address == 2'd2);
    assign wr_ctl = write && (address == 2'd3);
    // a finished vector refuses new pairs until cleared or re-armed
    assign issue  = write && (address == 2'd1) && !done;
    // any re-arm wipes the in-flight product as well as the result state
    assign flush  = wr_len || (wr_ctl && writedata[0]);
    // the accumulate stage is the acc register itself, so only stage 1 holds work
    assign busy   = s1_valid;

    assign a_ext  = {{DATA_W{op_a[DATA_W-1]}}, op_a};
    assign b_ext  = {{DATA_W{op_b[DATA_W-1]}}, op_b};
    assign prod   = a_ext * b_ext;

    // sign-extend product, add, detect overflow and pick saturate or wrap result
    always_comb begin
        prod_ext   = {{(ACC_W + 1 - PROD_W){s1_prod[PROD_W-1]}}, s1_prod};
        sum        = {acc[ACC_W-1], acc} + prod_ext;
        sum_ovf    = sum[ACC_W] != sum[ACC_W-1];
        acc_next   = sum[ACC_W-1:0];
        count_next = count + {{(LEN_W-1){1'b0}}, 1'b1};
        if (SATURATE && sum_ovf) begin
            if (sum[ACC_W]) begin
                acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    // read data mux; the upper accumulator word is sign-extended
    always_comb begin
        rd_mux = 32'd0;
        case (address)
            2'd0:    rd_mux = acc[31:0];
            2'd1:    rd_mux = 32'(acc >>> 32);
            2'd2:    rd_mux = 32'(count);
            default: rd_mux = {28'd0, irq_en, ovf, busy, done};
        endcase
    end

    // configuration registers, pipeline, accumulator and status
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a     <= '0;
            length   <= '0;
            irq_en   <= 1'b0;
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            acc      <= '0;
            count    <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            irq      <= 1'b0;
            readdata <= 32'd0;
        end else begin
            if (wr_a) begin
                op_a <= writedata[DATA_W-1:0];
            end
            if (wr_len) begin
                length <= writedata[LEN_W-1:0];
            end
            if (wr_ctl) begin
                irq_en <= writedata[1];
            end
            s1_valid <= issue && !flush;
            if (issue) begin
                s1_prod <= prod;
            end
            if (flush) begin
                acc   <= '0;
                count <= '0;
                done  <= 1'b0;
                ovf   <= 1'b0;
            end else if (s1_valid) begin
                acc   <= acc_next;
                count <= count_next;
                if (sum_ovf) begin
                    ovf <= 1'b1;
                end
                if ((length != '0) && (count_next == length)) begin
                    done <= 1'b1;
                end
            end
            irq <= done && irq_en;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_vector_dot_acc.sv
// tb/tb_vector_dot_acc.sv - directed self-checking bench for vector_dot_acc
module tb_vector_dot_acc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = 32'd0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] rd_main, rd_sat, rd_wrap;
    logic        irq_main, irq_sat, irq_wrap;
    logic [31:0] v_main, v_sat, v_wrap;

    int total = 0;
    int bad = 0;

    vector_dot_acc #(.DATA_W(16), .ACC_W(40), .LEN_W(16), .SATURATE(1'b1)) u_main (
        .clk(clk), .reset(reset), .address(address), .writedata(writedata),
        .write(write), .read(read), .readdata(rd_main), .irq(irq_main));

    vector_dot_acc #(.DATA_W(16), .ACC_W(32), .LEN_W(16), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .address(address), .writedata(writedata),
        .write(write), .read(read), .readdata(rd_sat), .irq(irq_sat));

    vector_dot_acc #(.DATA_W(16), .ACC_W(32), .LEN_W(16), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .address(address), .writedata(writedata),
        .write(write), .read(read), .readdata(rd_wrap), .irq(irq_wrap));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        v_main  = rd_main;
        v_sat   = rd_sat;
        v_wrap  = rd_wrap;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset_readdata", rd_main, 32'd0);
        chk("reset_irq", {31'd0, irq_main}, 32'd0);
        bus_rd(2'd3);
        chk("reset_status", v_main, 32'd0);

        // 1*2 + 3*4 + 5*6 = 44, irq three cycles after last pair
        bus_wr(2'd3, 32'd2);
        bus_wr(2'd2, 32'd3);
        bus_wr(2'd0, 32'd1); bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'd3); bus_wr(2'd1, 32'd4);
        bus_wr(2'd0, 32'd5); bus_wr(2'd1, 32'd6);
        tick();
        chk("t1_irq_early", {31'd0, irq_main}, 32'd0);
        tick();
        chk("t1_irq", {31'd0, irq_main}, 32'd1);
        bus_rd(2'd0); chk("t1_acc_lo", v_main, 32'd44);
        bus_rd(2'd1); chk("t1_acc_hi", v_main, 32'd0);
        bus_rd(2'd2); chk("t1_count", v_main, 32'd3);
        bus_rd(2'd3); chk("t1_status", v_main, 32'h9);

        // (-3)*7 + 2*(-5) = -31
        bus_wr(2'd2, 32'd2);
        bus_wr(2'd0, 32'hFFFF_FFFD); bus_wr(2'd1, 32'd7);
        bus_wr(2'd0, 32'd2);         bus_wr(2'd1, 32'hFFFF_FFFB);
        tick();
        tick();
        bus_rd(2'd0); chk("t2_acc_lo", v_main, 32'hFFFF_FFE1);
        bus_rd(2'd1); chk("t2_acc_hi", v_main, 32'hFFFF_FFFF);
        bus_rd(2'd3); chk("t2_status", v_main, 32'h9);

        // three 32767^2 pairs overflow a 32-bit accumulator
        bus_wr(2'd2, 32'd0);
        bus_wr(2'd0, 32'd32767);
        bus_wr(2'd1, 32'd32767);
        bus_wr(2'd1, 32'd32767);
        bus_wr(2'd1, 32'd32767);
        tick();
        tick();
        bus_rd(2'd0);
        chk("t3_sat_acc", v_sat, 32'h7FFF_FFFF);
        chk("t3_wrap_acc", v_wrap, 32'hBFFD_0003);
        chk("t3_wide_acc", v_main, 32'hBFFD_0003);
        bus_rd(2'd3);
        chk("t3_sat_status", v_sat, 32'hC);
        chk("t3_wrap_status", v_wrap, 32'hC);
        chk("t3_wide_status", v_main, 32'h8);
        bus_rd(2'd1);
        chk("t3_wide_hi", v_main, 32'd0);
        chk("t3_sat_hi", v_sat, 32'd0);

        // back-to-back pairs 2*1..2*5, result two cycles after last write
        bus_wr(2'd2, 32'd0);
        bus_wr(2'd0, 32'd2);
        for (int i = 1; i <= 5; i++) begin
            bus_wr(2'd1, 32'(i));
        end
        bus_rd(2'd3); chk("t4_busy", v_main, 32'hA);
        bus_rd(2'd0); chk("t4_acc", v_main, 32'd30);
        bus_rd(2'd3); chk("t4_idle", v_main, 32'h8);
        bus_rd(2'd2); chk("t4_count", v_main, 32'd5);
        tick();
        chk("t4_hold", rd_main, 32'd5);

        // LENGTH=1: pair after done is dropped
        bus_wr(2'd2, 32'd1);
        bus_wr(2'd0, 32'd4); bus_wr(2'd1, 32'd4);
        bus_wr(2'd0, 32'd9); bus_wr(2'd1, 32'd9);
        tick();
        tick();
        bus_rd(2'd0); chk("t5_acc", v_main, 32'd16);
        bus_rd(2'd2); chk("t5_count", v_main, 32'd1);
        bus_rd(2'd3); chk("t5_status", v_main, 32'h9);

        // clear lands on the cycle the pending product would accumulate
        bus_wr(2'd3, 32'd3);
        bus_wr(2'd0, 32'd3); bus_wr(2'd1, 32'd3);
        bus_wr(2'd3, 32'd3);
        tick();
        tick();
        bus_rd(2'd0); chk("t6_acc", v_main, 32'd0);
        bus_rd(2'd2); chk("t6_count", v_main, 32'd0);
        bus_rd(2'd3); chk("t6_status", v_main, 32'h8);

        // reset during streaming
        bus_wr(2'd2, 32'd3);
        bus_wr(2'd0, 32'd5);
        bus_wr(2'd1, 32'd1); bus_wr(2'd1, 32'd2); bus_wr(2'd1, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_readdata", rd_main, 32'd0);
        chk("t7_irq", {31'd0, irq_main}, 32'd0);
        tick();
        for (int a = 0; a < 4; a++) begin
            bus_rd(2'(a));
            chk($sformatf("t7_rd%0d", a), v_main, 32'd0);
        end
        tick();
        tick();
        chk("t7_irq_late", {31'd0, irq_main}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
